// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared constants for the AES-256 key schedule:
//   - key schedule dimensions (words per key, rounds, number of round keys)
//   - FSM state encoding for the iterative key expander
//   - the AES forward S-box table used by aes_sbox
//   - rcon(): round constant lookup, valid for indices 1..7
// ---------------------------------------------------------------------------
package aes_pkg;

    localparam int NK       = 8;
    localparam int NR       = 14;
    localparam int NUM_RK   = NR + 1;
    localparam int KEY_BITS = 32 * NK;

    // Index of the final round key (rk14).
    localparam logic [3:0] LAST_IDX = 4'(NUM_RK - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // AES-256 only ever needs Rcon[1..7]; anything else returns zero and is
    // only reached for schedule positions past rk14, whose value is unused.
    function automatic logic [7:0] rcon(input logic [3:0] i);
        logic [7:0] r;
        case (i)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// ---------------------------------------------------------------------------
// aes_sbox
// AES forward S-box, purely combinational table lookup.
//   din  : input byte
//   dout : substituted byte
// ---------------------------------------------------------------------------
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] din,
    output logic [7:0] dout
);

    assign dout = SBOX[din];

endmodule

// File: rtl/sub_word.sv
// ---------------------------------------------------------------------------
// sub_word
// AES SubWord: applies the S-box to each byte of a 32-bit word.
// Purely combinational.
//   din  : input word  {b0,b1,b2,b3}, b0 in bits [31:24]
//   dout : output word {S(b0),S(b1),S(b2),S(b3)}
// ---------------------------------------------------------------------------
module sub_word (
    input  logic [31:0] din,
    output logic [31:0] dout
);

    aes_sbox u_sbox3 (.din(din[31:24]), .dout(dout[31:24]));
    aes_sbox u_sbox2 (.din(din[23:16]), .dout(dout[23:16]));
    aes_sbox u_sbox1 (.din(din[15:8]),  .dout(dout[15:8]));
    aes_sbox u_sbox0 (.din(din[7:0]),   .dout(dout[7:0]));

endmodule

// File: rtl/aes256_key_expand.sv
// ---------------------------------------------------------------------------
// aes256_key_expand
// Iterative AES-256 key schedule. Loads a 256-bit cipher key on start and
// streams round keys rk0..rk14 over a valid/ready handshake, one key per
// accepted beat.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous reset, active-high
//   start     load request, honoured only while idle
//   key       256-bit cipher key, w0 = key[255:224]
//   busy      high while the schedule is being streamed
//   rk_valid  round-key beat valid
//   rk_ready  consumer accepts the beat when rk_valid && rk_ready
//   rk_idx    index 0..14 of the round key currently on rk
//   rk        128-bit round key, rk[127:96] = w[4*rk_idx]
//   done      one-cycle pulse on the cycle after rk14 is accepted
//
// Two 128-bit window registers hold rk[idx] (presented) and rk[idx+1]; each
// accepted beat slides the window and computes rk[idx+2] from both halves.
// ---------------------------------------------------------------------------
module aes256_key_expand
    import aes_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [KEY_BITS-1:0] key,
    output logic                busy,
    output logic                rk_valid,
    input  logic                rk_ready,
    output logic [3:0]          rk_idx,
    output logic [127:0]        rk,
    output logic                done
);

    state_t        state_q, state_d;
    logic [3:0]    idx_q,   idx_d;
    logic [127:0]  win_a_q, win_a_d;
    logic [127:0]  win_b_q, win_b_d;
    logic          done_q,  done_d;

    logic [4:0]    n;
    logic          n_even;
    logic [31:0]   t_word;
    logic [31:0]   sub_in;
    logic [31:0]   sub_out;
    logic [31:0]   t_mix;
    logic [31:0]   w0, w1, w2, w3;
    logic [127:0]  next_rk;

    // n is the schedule position of the key being generated (idx+2). Even
    // positions start a new 256-bit block and take RotWord plus Rcon; odd
    // positions take the extra SubWord that only AES-256 has.
    assign n       = {1'b0, idx_q} + 5'd2;
    assign n_even  = ~n[0];
    assign t_word  = win_b_q[31:0];
    assign sub_in  = n_even ? {t_word[23:0], t_word[31:24]} : t_word;

    sub_word u_sub_word (
        .din  (sub_in),
        .dout (sub_out)
    );

    assign t_mix = n_even ? (sub_out ^ {rcon(n[4:1]), 24'h000000}) : sub_out;

    // Each word depends on the one just produced, so the four XORs form a
    // single combinational chain within the cycle.
    assign w0      = win_a_q[127:96] ^ t_mix;
    assign w1      = win_a_q[95:64]  ^ w0;
    assign w2      = win_a_q[63:32]  ^ w1;
    assign w3      = win_a_q[31:0]   ^ w2;
    assign next_rk = {w0, w1, w2, w3};

    // State and window registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 4'd0;
            win_a_q <= 128'd0;
            win_b_q <= 128'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            win_a_q <= win_a_d;
            win_b_q <= win_b_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic. The key is captured only here, on an accepted start,
    // so later activity on key cannot disturb a running schedule.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        win_a_d = win_a_q;
        win_b_d = win_b_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    win_a_d = key[KEY_BITS-1 -: 128];
                    win_b_d = key[127:0];
                    idx_d   = 4'd0;
                    state_d = RUN;
                end
            end

            RUN: begin
                if (rk_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        win_a_d = win_b_q;
                        win_b_d = next_rk;
                        idx_d   = idx_q + 4'd1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy     = (state_q == RUN);
    assign rk_valid = (state_q == RUN);
    assign rk_idx   = idx_q;
    assign rk       = win_a_q;
    assign done     = done_q;

endmodule

// File: doc/aes256_key_expand.md
Name: aes256_key_expand

Overview:
- Iterative AES-256 key schedule (FIPS-197, Nk=8, Nr=14) for the CTR datapath.
- Loads a 256-bit cipher key and emits the 15 round keys rk0..rk14 in order, one 128-bit key per accepted beat, over a valid/ready stream.
- Sits upstream of the round pipeline's AddRoundKey.
- Contains four existing sbox instances for SubWord.

Parameters:
- None. Nk=8, Nr=14 and the Rcon table are package constants. This block is AES-256 only.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- start  input  1  one-cycle load request; sampled only in IDLE
- key  input  256  cipher key, FIPS-197 byte order; w0 = key[255:224]
- busy  output  1  high from the cycle after an accepted start until the cycle after rk14 is accepted
- rk_valid  output  1  round-key beat valid
- rk_ready  input  1  consumer accepts the beat when rk_valid && rk_ready
- rk_idx  output  4  index (0..14) of the round key on rk
- rk  output  128  round key; rk[127:96] = w[4*rk_idx]
- done  output  1  one-cycle pulse on the cycle after rk14 is accepted

Behaviour:
- Reset (async, any time including mid-schedule):
  - Outputs: busy=0, rk_valid=0, rk_idx=0, rk=0, done=0.
  - Internal state: window registers cleared, state=IDLE.
- State: two 128-bit window registers.
  - win_a = rk[idx], driven on rk.
  - win_b = rk[idx+1].
- States: IDLE, RUN.
- IDLE:
  - start=1 loads win_a=key[255:128] and win_b=key[127:0], sets idx=0, goes to RUN.
  - Next cycle: busy=1, rk_valid=1, rk_idx=0. Load-to-first-beat latency is 1 cycle.
- RUN:
  - rk_valid is held at 1. rk and rk_idx stay stable while rk_ready=0 (no retraction, no change).
  - On accept with idx<14: win_a<=win_b, win_b<=next, idx<=idx+1. Throughput is one key per cycle under continuous rk_ready.
  - On accept with idx=14: go to IDLE. Next cycle: rk_valid=0, busy=0, done=1 for exactly one cycle.
- next = rk[n] with n = idx+2, built combinationally from win_a (w[4n-8..4n-5]) and win_b (w[4n-4..4n-1]):
  - t = w[4n-1] (low word of win_b).
  - n even: T = SubWord(RotWord(t)) ^ {Rcon[n/2],24'h0}, with Rcon[1..7] = 01,02,04,08,10,20,40.
  - n odd: T = SubWord(t), no rotate, no Rcon.
  - w[4n] = w[4n-8] ^ T.
  - w[4n+k] = w[4n+k-8] ^ w[4n+k-1] for k = 1..3, chained within the same cycle.
  - When n>14 the computed value is don't-care and is never presented.
- RotWord: {b1,b2,b3,b0} of {b0,b1,b2,b3}.
- SubWord: bytewise sbox. All XORs are 32-bit; no carries.
- start outside IDLE is ignored, including in the same cycle as the idx=14 accept.
- start is accepted in the cycle done is high (state is IDLE). rk_valid then rises the following cycle with idx=0.
- key is sampled only on an accepted start. Later changes to key have no effect on the running schedule.

Decomposition:
- Package aes_pkg:
  - constants NK=8, NR=14, NUM_RK=15.
  - rcon function/table indexed 1..7.
  - state enum {IDLE, RUN}.
- Sub-module sub_word: 32-bit in/out, four sbox instances, purely combinational. Instantiated once.
- RotWord, Rcon XOR and the chained word XORs stay inline in aes256_key_expand.

Test Plan:
- FIPS-197 A.3 key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, rk_ready=1 -> beats on consecutive cycles starting 1 cycle after start:
  - rk0 = 603deb1015ca71be2b73aef0857d7781
  - rk1 = 1f352c073b6108d72d9810a30914dff4
  - rk2 = 9ba354118e6925afa51a8b5f2067fcde
  - rk3 = a8b09c1a93d194cdbe49846eb75d5b9a
  - rk14 = fe4890d1e6188d0b046df344706c631e
  - done pulses 1 cycle after rk14; busy is high for 15 cycles.
- All-zero key -> rk0 = rk1 = 0; rk2 = 62636363626363636263636362636363; rk3 = aafbfbfbaafbfbfbaafbfbfbaafbfbfb.
- Random rk_ready backpressure (~50%) on the A.3 key -> rk/rk_idx stable while stalled; same 15-key sequence; no skipped or duplicated idx.
- start pulsed during RUN with a different key -> ignored; sequence continues unchanged. start in the done cycle -> new schedule, rk_idx=0 the next cycle.
- rst asserted asynchronously at idx=7 -> all outputs 0 immediately. Fresh start afterwards -> correct full sequence from rk0.
- Change key every cycle after start is accepted -> outputs match the key value captured at start.
